logic_issue: RTL and testbench

LOGIC_ISSUE -- requirements
Module: logic_issue

---
 rtl/logic_issue.sv | 125 ++++++++++++
 tb/tb_logic_issue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue.sv
// logic_issue: 8 x 8-bit register file driving an external logical unit through a
// three-state IDLE -> EXEC -> WB sequencer. One operation completes every 3 cycles.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i          operation request (accepted only in IDLE)
//   req_ready_o          high in IDLE only
//   req_op_i             0 = OR, 1 = AND
//   req_rs_i, req_rt_i   source register indices
//   req_rd_i             destination register index
//   ld_valid_i/addr/data register preload (IDLE only)
//   rd_addr_i/rd_data_o  combinational observation read
//   lu_a_o, lu_b_o       registered operands to the logical unit
//   lu_op_o              registered op select to the logical unit
//   lu_y_i               combinational result from the logical unit
//   done_o, done_data_o  one-cycle completion pulse and written-back value
module logic_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_op_i,
  input  logic [2:0] req_rs_i,
  input  logic [2:0] req_rt_i,
  input  logic [2:0] req_rd_i,
  input  logic       ld_valid_i,
  input  logic [2:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  input  logic [2:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic [7:0] lu_a_o,
  output logic [7:0] lu_b_o,
  output logic       lu_op_o,
  input  logic [7:0] lu_y_i,
  output logic       done_o,
  output logic [7:0] done_data_o
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e     state_q, state_d;
  logic [7:0] rf_q [8];
  logic [7:0] rf_d [8];
  logic [7:0] lu_a_q, lu_a_d;
  logic [7:0] lu_b_q, lu_b_d;
  logic       lu_op_q, lu_op_d;
  logic [2:0] rd_q, rd_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic [7:0] done_data_q, done_data_d;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_op_d     = lu_op_q;
    rd_d        = rd_q;
    result_d    = result_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;

    case (state_q)
      StIdle: begin
        // Operands come from rf_q, so a coincident load is not visible to this request.
        if (ld_valid_i) begin
          rf_d[ld_addr_i] = ld_data_i;
        end
        if (req_valid_i) begin
          lu_a_d  = rf_q[req_rs_i];
          lu_b_d  = rf_q[req_rt_i];
          lu_op_d = req_op_i;
          rd_d    = req_rd_i;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = lu_y_i;
        state_d  = StWb;
      end
      StWb: begin
        rf_d[rd_q]  = result_q;
        done_d      = 1'b1;
        done_data_d = result_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 8'h00;
      end
      lu_a_q      <= 8'h00;
      lu_b_q      <= 8'h00;
      lu_op_q     <= 1'b0;
      rd_q        <= 3'd0;
      result_q    <= 8'h00;
      done_q      <= 1'b0;
      done_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_op_q     <= lu_op_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rd_data_o   = rf_q[rd_addr_i];
  assign lu_a_o      = lu_a_q;
  assign lu_b_o      = lu_b_q;
  assign lu_op_o     = lu_op_q;
  assign done_o      = done_q;
  assign done_data_o = done_data_q;

endmodule

// File: tb/tb_logic_issue.sv
// Scoreboard bench for logic_issue: stimulus pushes expected done_data values,
// a negedge monitor pops and compares on every done pulse.
module tb_logic_issue;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [2:0] req_rs, req_rt, req_rd;
  logic       ld_valid;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] lu_a, lu_b, lu_y;
  logic       lu_op;
  logic       done;
  logic [7:0] done_data;

  int checks   = 0;
  int failures = 0;
  int dones    = 0;
  logic [7:0] exp_q [$];

  // External logical unit.
  assign lu_y = lu_op ? (lu_a & lu_b) : (lu_a | lu_b);

  logic_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_rs_i    (req_rs),
    .req_rt_i    (req_rt),
    .req_rd_i    (req_rd),
    .ld_valid_i  (ld_valid),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .lu_a_o      (lu_a),
    .lu_b_o      (lu_b),
    .lu_op_o     (lu_op),
    .lu_y_i      (lu_y),
    .done_o      (done),
    .done_data_o (done_data)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic set_req(input logic op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
  endtask

  // Monitor: every done pulse must match the oldest expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        dones++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done_data 0x%02h expected no done", done_data);
        end else begin
          check("done_data", done_data, exp_q.pop_front());
        end
      end
    end
  end

  logic [7:0] exp4 [3];

  initial begin
    exp4      = '{8'hFC, 8'h3C, 8'hFC};
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_rs    = 3'd0;
    req_rt    = 3'd0;
    req_rd    = 3'd0;
    ld_valid  = 1'b0;
    ld_addr   = 3'd0;
    ld_data   = 8'h00;
    rd_addr   = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    for (int i = 0; i < 8; i++) begin
      read_reg("reset_rf", 3'(i), 8'h00);
    end
    check("reset_ready", {7'b0, req_ready}, 8'h01);
    check("reset_done", {7'b0, done}, 8'h00);
    check("reset_lu_a", lu_a, 8'h00);

    // OR r1|r2 -> r3; also a load attempted in EXEC must be ignored.
    load(3'd1, 8'hF0);
    load(3'd2, 8'h3C);
    set_req(1'b0, 3'd1, 3'd2, 3'd3);
    exp_q.push_back(8'hFC);
    tick();
    req_valid = 1'b0;
    check("or_lu_a", lu_a, 8'hF0);
    check("or_lu_b", lu_b, 8'h3C);
    check("or_lu_op", {7'b0, lu_op}, 8'h00);
    check("exec_ready", {7'b0, req_ready}, 8'h00);
    ld_valid = 1'b1;
    ld_addr  = 3'd0;
    ld_data  = 8'h99;
    tick();
    ld_valid = 1'b0;
    check("wb_ready", {7'b0, req_ready}, 8'h00);
    check("wb_done", {7'b0, done}, 8'h00);
    check("wb_lu_a_hold", lu_a, 8'hF0);
    tick();
    check("lat_done", {7'b0, done}, 8'h01);
    check("lat_ready", {7'b0, req_ready}, 8'h01);
    read_reg("or_r3_wb_cycle", 3'd3, 8'hFC);
    tick();
    check("idle_lu_a_hold", lu_a, 8'hF0);
    read_reg("exec_load_ignored_r0", 3'd0, 8'h00);

    // AND r1&r2 -> r1.
    set_req(1'b1, 3'd1, 3'd2, 3'd1);
    exp_q.push_back(8'h30);
    tick();
    req_valid = 1'b0;
    check("and_lu_op", {7'b0, lu_op}, 8'h01);
    tick();
    tick();
    read_reg("and_r1", 3'd1, 8'h30);
    read_reg("and_r2", 3'd2, 8'h3C);

    // Continuous requests, alternating op: accepts on edges 0, 3, 6 only.
    for (int k = 0; k < 9; k++) begin
      set_req(1'(k % 2), 3'd2, 3'd3, 3'd6);
      if (k % 3 == 0) exp_q.push_back(exp4[k / 3]);
      tick();
      check("stream_ready", {7'b0, req_ready}, (k % 3 == 2) ? 8'h01 : 8'h00);
    end
    req_valid = 1'b0;
    tick();
    read_reg("stream_r6", 3'd6, 8'hFC);

    // Load and request together: operands see the old r1.
    load(3'd1, 8'h0F);
    ld_valid = 1'b1;
    ld_addr  = 3'd1;
    ld_data  = 8'hAA;
    set_req(1'b0, 3'd1, 3'd1, 3'd4);
    exp_q.push_back(8'h0F);
    tick();
    ld_valid  = 1'b0;
    req_valid = 1'b0;
    check("coinc_lu_a", lu_a, 8'h0F);
    tick();
    tick();
    read_reg("coinc_r1", 3'd1, 8'hAA);
    read_reg("coinc_r4", 3'd4, 8'h0F);

    // Reset during EXEC abandons the write to r5.
    load(3'd7, 8'h55);
    set_req(1'b0, 3'd7, 3'd7, 3'd5);
    tick();
    req_valid = 1'b0;
    check("pre_rst_ready", {7'b0, req_ready}, 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_ready", {7'b0, req_ready}, 8'h01);
    check("rst_lu_a", lu_a, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    read_reg("rst_r5", 3'd5, 8'h00);
    read_reg("rst_r7", 3'd7, 8'h00);
    check("post_rst_ready", {7'b0, req_ready}, 8'h01);

    tick();
    check("sb_empty", 8'(exp_q.size()), 8'h00);
    check("done_count", 8'(dones), 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
